// File: rtl/instr_register_pkg.sv
// ============================================================================
// instr_register_pkg : shared types and constants for the instruction register
// arbiter. Revision 1.0
// ============================================================================
`default_nettype none

package instr_register_pkg;

  localparam int NUM_LOCATIONS = 32;

  typedef enum logic [2:0] {
    ZERO  = 3'd0,
    PASSA = 3'd1,
    PASSB = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    MULT  = 3'd5,
    DIV   = 3'd6,
    MOD   = 3'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic [4:0]         address_t;
  typedef logic [5:0]         count_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } arb_state_t;

  function automatic count_t popcount32(input logic [NUM_LOCATIONS-1:0] bits);
    count_t n;
    n = '0;
    for (int i = 0; i < NUM_LOCATIONS; i++) begin
      n = n + count_t'(bits[i]);
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_reg_arbiter_if.sv
// ============================================================================
// instr_reg_arbiter_if : requester, read and instruction-register signals.
// Revision 1.0
// ============================================================================
`default_nettype none

interface instr_reg_arbiter_if;
  import instr_register_pkg::*;

  logic     req0_valid;
  logic     req0_ready;
  opcode_t  req0_opcode;
  operand_t req0_op_a;
  operand_t req0_op_b;

  logic     req1_valid;
  logic     req1_ready;
  opcode_t  req1_opcode;
  operand_t req1_op_a;
  operand_t req1_op_b;

  logic     rd_req;
  address_t rd_addr;
  logic     rd_ack;
  logic     rd_hit;

  logic     ir_load_en;
  address_t ir_write_pointer;
  address_t ir_read_pointer;
  opcode_t  ir_opcode;
  operand_t ir_operand_a;
  operand_t ir_operand_b;

  logic     flush;
  count_t   wr_count;
  logic     full;
  logic     last_winner;

  modport master (
    output req0_valid, req0_opcode, req0_op_a, req0_op_b,
    output req1_valid, req1_opcode, req1_op_a, req1_op_b,
    output rd_req, rd_addr, flush,
    input  req0_ready, req1_ready, rd_ack, rd_hit,
    input  ir_load_en, ir_write_pointer, ir_read_pointer,
    input  ir_opcode, ir_operand_a, ir_operand_b,
    input  wr_count, full, last_winner
  );

  modport slave (
    input  req0_valid, req0_opcode, req0_op_a, req0_op_b,
    input  req1_valid, req1_opcode, req1_op_a, req1_op_b,
    input  rd_req, rd_addr, flush,
    output req0_ready, req1_ready, rd_ack, rd_hit,
    output ir_load_en, ir_write_pointer, ir_read_pointer,
    output ir_opcode, ir_operand_a, ir_operand_b,
    output wr_count, full, last_winner
  );

endinterface

`default_nettype wire

// File: rtl/instr_reg_arbiter_rr_arbiter2.sv
// ============================================================================
// rr_arbiter2 : two-way round-robin grant, one-hot output. Revision 1.0
// ============================================================================
`default_nettype none

module rr_arbiter2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_winner,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (valid0 && valid1) begin
      // On a tie the requester that did not win last time goes next.
      grant = last_winner ? 2'b01 : 2'b10;
    end else if (valid0) begin
      grant = 2'b01;
    end else if (valid1) begin
      grant = 2'b10;
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_reg_arbiter.sv
// ============================================================================
// instr_reg_arbiter : arbitrates two requesters into a 32-entry instruction
// register with sequential allocation, valid tracking and a read port. Rev 1.0
// ============================================================================
`default_nettype none

module instr_reg_arbiter
  import instr_register_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  instr_reg_arbiter_if.slave  bus
);

  arb_state_t                 r_state;
  arb_state_t                 w_next_state;
  logic [1:0]                 w_grant;
  logic                       w_can_accept;
  logic                       w_accept;
  instruction_t               w_win_instr;

  address_t                   r_wr_ptr;
  count_t                     r_alloc;
  logic [NUM_LOCATIONS-1:0]   r_valid;

  logic                       r_load_en;
  address_t                   r_load_addr;
  instruction_t               r_instr;
  logic                       r_last_winner;

  logic                       r_rd_ack;
  address_t                   r_rd_ptr;
  count_t                     w_wr_count;

  rr_arbiter2 u_rr (
    .valid0      (bus.req0_valid),
    .valid1      (bus.req1_valid),
    .last_winner (r_last_winner),
    .grant       (w_grant)
  );

  // r_alloc counts accepts still in flight too, so the 32nd accept closes
  // the door before its valid bit lands and nothing is ever overwritten.
  assign w_can_accept = !reset && !bus.flush && (r_state != FULL)
                        && (r_alloc != count_t'(NUM_LOCATIONS));
  assign w_accept     = w_can_accept && (|w_grant);

  assign bus.req0_ready = w_can_accept && w_grant[0];
  assign bus.req1_ready = w_can_accept && w_grant[1];

  always_comb begin
    w_win_instr = '{opc: bus.req0_opcode, op_a: bus.req0_op_a, op_b: bus.req0_op_b};
    if (w_grant[1]) begin
      w_win_instr = '{opc: bus.req1_opcode, op_a: bus.req1_op_a, op_b: bus.req1_op_b};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next_state = LOAD;
      end
      LOAD: begin
        if (r_load_en && (r_load_addr == address_t'(NUM_LOCATIONS - 1))) begin
          w_next_state = FULL;
        end else if (w_accept) begin
          w_next_state = LOAD;
        end else begin
          w_next_state = IDLE;
        end
      end
      FULL:    w_next_state = FULL;
      default: w_next_state = IDLE;
    endcase
    if (bus.flush) w_next_state = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_load_en     <= 1'b0;
      r_load_addr   <= '0;
      r_instr       <= '0;
      r_last_winner <= 1'b1;
    end else begin
      r_load_en <= w_accept;
      if (w_accept) begin
        r_load_addr   <= r_wr_ptr;
        r_instr       <= w_win_instr;
        r_last_winner <= w_grant[1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_alloc  <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_alloc  <= '0;
    end else if (w_accept) begin
      r_wr_ptr <= r_wr_ptr + address_t'(1);
      r_alloc  <= r_alloc + count_t'(1);
    end
  end

  // A load completing during a flush still pulses but leaves its bit clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
    end else if (bus.flush) begin
      r_valid <= '0;
    end else if (r_load_en) begin
      r_valid[r_load_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ack <= 1'b0;
      r_rd_ptr <= '1;
    end else begin
      r_rd_ack <= bus.rd_req;
      if (bus.rd_req) r_rd_ptr <= bus.rd_addr;
    end
  end

  assign w_wr_count = popcount32(r_valid);

  assign bus.rd_ack           = r_rd_ack;
  assign bus.rd_hit           = r_rd_ack && (r_valid[r_rd_ptr]
                                || (r_load_en && (r_load_addr == r_rd_ptr)));
  assign bus.ir_load_en       = r_load_en;
  assign bus.ir_write_pointer = r_load_addr;
  assign bus.ir_read_pointer  = r_rd_ptr;
  assign bus.ir_opcode        = r_instr.opc;
  assign bus.ir_operand_a     = r_instr.op_a;
  assign bus.ir_operand_b     = r_instr.op_b;
  assign bus.wr_count         = w_wr_count;
  assign bus.full             = (w_wr_count == count_t'(NUM_LOCATIONS));
  assign bus.last_winner      = r_last_winner;

endmodule

`default_nettype wire

// File: tb/tb_instr_reg_arbiter.sv
// ============================================================================
// tb_instr_reg_arbiter : directed and random stimulus against a queue-based
// scoreboard for instr_reg_arbiter. Revision 1.0
// ============================================================================
`default_nettype none

module tb_instr_reg_arbiter;
  import instr_register_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_reg_arbiter_if bus();

  instr_reg_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    address_t addr;
    opcode_t  op;
    operand_t a;
    operand_t b;
  } load_exp_t;

  typedef struct {
    address_t addr;
    logic     hit;
  } read_exp_t;

  load_exp_t load_q[$];
  read_exp_t read_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model: which locations hold data, how many were handed out,
  // where the next one goes and who won last.
  bit m_valid[32];
  int m_alloc;
  int m_ptr;
  int m_last;
  bit m_pend;
  int m_pend_addr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < 32; i++) n += m_valid[i];
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
    m_alloc = 0; m_ptr = 0; m_last = 1; m_pend = 1'b0; m_pend_addr = 0;
    load_q.delete();
    read_q.delete();
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.rd_req = 1'b0; bus.flush = 1'b0;
  endtask

  // Called just after a posedge; returns just after the next posedge.
  task automatic do_cycle(input bit v0, input bit v1, input bit rq, input int ra,
                          input bit fl, input opcode_t o0, input operand_t a0,
                          input operand_t b0);
    opcode_t   o1;
    operand_t  a1, b1;
    bit        space, g0, g1, acc, hit;
    load_exp_t le;
    read_exp_t re;
    o1 = opcode_t'($urandom_range(0, 7));
    a1 = operand_t'($urandom);
    b1 = operand_t'($urandom);
    bus.req0_valid = v0; bus.req0_opcode = o0; bus.req0_op_a = a0; bus.req0_op_b = b0;
    bus.req1_valid = v1; bus.req1_opcode = o1; bus.req1_op_a = a1; bus.req1_op_b = b1;
    bus.rd_req = rq; bus.rd_addr = address_t'(ra); bus.flush = fl;

    space = (m_alloc < 32);
    g0 = !fl && space && v0 && (!v1 || m_last == 1);
    g1 = !fl && space && v1 && (!v0 || m_last == 0);
    acc = g0 || g1;

    @(negedge clk);
    chk("req0_ready", bus.req0_ready, g0);
    chk("req1_ready", bus.req1_ready, g1);
    chk("wr_count", bus.wr_count, model_count());
    chk("full", bus.full, model_count() == 32);
    chk("last_winner", bus.last_winner, m_last);
    if (acc) begin
      le.addr = address_t'(m_ptr);
      le.op = g1 ? o1 : o0;
      le.a  = g1 ? a1 : a0;
      le.b  = g1 ? b1 : b0;
      load_q.push_back(le);
    end
    if (rq) begin
      hit = fl ? 1'b0 : (m_valid[ra] || (m_pend && m_pend_addr == ra));
      hit = hit || (acc && m_ptr == ra);
      re.addr = address_t'(ra);
      re.hit = hit;
      read_q.push_back(re);
    end

    @(posedge clk);
    if (fl) begin
      for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
    end else if (m_pend) begin
      m_valid[m_pend_addr] = 1'b1;
    end
    m_pend = acc;
    m_pend_addr = m_ptr;
    if (fl) begin
      m_ptr = 0; m_alloc = 0;
    end else if (acc) begin
      m_ptr = (m_ptr + 1) % 32; m_alloc++;
    end
    if (g0) m_last = 0;
    else if (g1) m_last = 1;
    #1;
    idle_inputs();
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 0, 0, ZERO, 0, 0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_load_en"}, bus.ir_load_en, 0);
    chk({tag, "_wr_ptr"}, bus.ir_write_pointer, 0);
    chk({tag, "_rd_ptr"}, bus.ir_read_pointer, 5'h1F);
    chk({tag, "_opcode"}, bus.ir_opcode, 0);
    chk({tag, "_op_a"}, bus.ir_operand_a, 0);
    chk({tag, "_op_b"}, bus.ir_operand_b, 0);
    chk({tag, "_rd_ack"}, bus.rd_ack, 0);
    chk({tag, "_rd_hit"}, bus.rd_hit, 0);
    chk({tag, "_wr_count"}, bus.wr_count, 0);
    chk({tag, "_full"}, bus.full, 0);
    chk({tag, "_last_winner"}, bus.last_winner, 1);
    chk({tag, "_ready0"}, bus.req0_ready, 0);
    chk({tag, "_ready1"}, bus.req1_ready, 0);
  endtask

  // Asserts reset just after a posedge; any load pulse in flight is aborted.
  task automatic reset_dut(input string tag);
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    reset = 1'b1;
    #1;
    check_reset_values(tag);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_inputs();
  endtask

  // Monitor: compares every load pulse and read acknowledge with the queue head.
  initial begin
    load_exp_t le;
    read_exp_t re;
    forever begin
      @(negedge clk);
      if (bus.ir_load_en === 1'b1) begin
        if (load_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_load: got ir_load_en=1 at ptr %0d expected no load", bus.ir_write_pointer);
        end else begin
          le = load_q.pop_front();
          chk("load_addr", bus.ir_write_pointer, le.addr);
          chk("load_opcode", bus.ir_opcode, le.op);
          chk("load_op_a", bus.ir_operand_a, le.a);
          chk("load_op_b", bus.ir_operand_b, le.b);
        end
      end
      if (bus.rd_ack === 1'b1) begin
        if (read_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: got rd_ack=1 expected no ack");
        end else begin
          re = read_q.pop_front();
          chk("read_ptr", bus.ir_read_pointer, re.addr);
          chk("read_hit", bus.rd_hit, re.hit);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req0_opcode = ZERO; bus.req0_op_a = '0; bus.req0_op_b = '0;
    bus.req1_opcode = ZERO; bus.req1_op_a = '0; bus.req1_op_b = '0;
    bus.rd_addr = '0;
    idle_inputs();
    reset = 1'b0;
    model_reset();
    #1;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    reset = 1'b1;
    #1;
    check_reset_values("por");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_inputs();

    // Single requester, fixed payload.
    do_cycle(1, 0, 0, 0, 0, ADD, 5, 3);
    chk("t025_load_en", bus.ir_load_en, 1);
    chk("t025_ptr", bus.ir_write_pointer, 0);
    chk("t025_opcode", bus.ir_opcode, ADD);
    chk("t025_op_a", bus.ir_operand_a, 5);
    chk("t025_op_b", bus.ir_operand_b, 3);
    quiet(1);
    chk("t025_wr_count", bus.wr_count, 1);

    // Round robin from reset: 0,1,0,1.
    reset_dut("rst1");
    for (int i = 0; i < 4; i++) do_cycle(1, 1, 0, 0, 0, SUB, operand_t'(i), operand_t'(i + 10));
    chk("t026_last", bus.last_winner, 1);
    quiet(1);

    // Reads after writes at 0..3.
    do_cycle(0, 0, 1, 2, 0, ZERO, 0, 0);
    chk("t028_ack2", bus.rd_ack, 1);
    chk("t028_hit2", bus.rd_hit, 1);
    do_cycle(0, 0, 1, 7, 0, ZERO, 0, 0);
    chk("t028_ack7", bus.rd_ack, 1);
    chk("t028_hit7", bus.rd_hit, 0);
    quiet(1);

    // Flush coincident with a request.
    do_cycle(1, 0, 0, 0, 1, MULT, 9, 9);
    chk("t030_wr_count", bus.wr_count, 0);
    do_cycle(1, 0, 0, 0, 0, DIV, 8, 2);
    chk("t030_ptr", bus.ir_write_pointer, 0);
    quiet(1);

    // Fill all 32, stall, flush, restart at 0.
    reset_dut("rst2");
    for (int i = 0; i < 32; i++)
      do_cycle(1, i % 3 == 0, 0, 0, 0, opcode_t'(i % 8), operand_t'(i), operand_t'(-i));
    do_cycle(1, 1, 0, 0, 0, MOD, 1, 1);
    do_cycle(1, 1, 1, 31, 0, MOD, 1, 1);
    chk("t027_full", bus.full, 1);
    chk("t027_wr_count", bus.wr_count, 32);
    chk("t027_ready0", bus.req0_ready, 0);
    chk("t027_ready1", bus.req1_ready, 0);
    do_cycle(0, 0, 0, 0, 1, ZERO, 0, 0);
    chk("t027_flush_count", bus.wr_count, 0);
    do_cycle(1, 0, 0, 0, 0, PASSA, 4, 4);
    chk("t027_restart_ptr", bus.ir_write_pointer, 0);
    quiet(1);

    // Reset in the load-pulse cycle aborts the write.
    do_cycle(0, 1, 0, 0, 0, ZERO, 0, 0);
    reset_dut("t029");
    quiet(1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      do_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 1) == 1, int'($urandom_range(0, 31)),
               $urandom_range(0, 39) == 0, opcode_t'($urandom_range(0, 7)),
               operand_t'($urandom), operand_t'($urandom));
    end
    quiet(3);
    chk("drain_loads", load_q.size(), 0);
    chk("drain_reads", read_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
